ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares one RAM port (if_ram, client side) between NREQ requesters, e.g. dev loader and CPU.
//  Each requester posts one transaction (op, data_type, addr, data_in) with a req/ack handshake.
//  Arbitration is round-robin. Exactly one RAM transaction is in flight at any time.
//  For a load, RAM data_out is captured and returned to the requester that owns it.
// PARAMETERS
//  NREQ        2  number of requesters, legal range 2..8
//  RD_LATENCY  1  cycles from op issue to a valid ram.data_out, legal range 1..7
// PORTS
//  clk        in   1                     system clock, rising edge
//  rst_n      in   1                     asynchronous reset, active low
//  req        in   NREQ                  req[i]: requester i posts a transaction; held until ack[i]
//  ack        out  NREQ                  ack[i]: one-cycle pulse, transaction i complete
//  op         in   NREQ x op_t           per-requester pkg_ram::op_t
//  data_type  in   NREQ x data_type_t    per-requester pkg_ram::data_type_t
//  addr       in   NREQ x RAM_ADDRW      per-requester address
//  data_in    in   NREQ x RAM_QUAD_SIZE  per-requester store data
//  data_out   out  NREQ x RAM_QUAD_SIZE  per-requester load result, registered
//  ram        if_ram.client              shared RAM port
// BEHAVIOUR
//  Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active low.
//  Reset values:
//   - state=IDLE, ack=0, data_out[*]=0
//   - ram.op=pkg_ram::OP_NOP; ram.addr, ram.data_in, ram.data_type = 0
//   - rr_ptr=0
//  FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE:
//   - If any req[i] is set, pick the winner: the first requester with req set, searching
//     rr_ptr, rr_ptr+1, ... modulo NREQ.
//   - Latch the winner's op, data_type, addr and data_in into registers, record the owner,
//     go to ISSUE.
//   - If no req is set, stay in IDLE.
//  ISSUE (1 cycle):
//   - ram.op = latched op.
//   - Set cnt = RD_LATENCY-1 and go to WAIT.
//  WAIT:
//   - ram.op = OP_NOP. Decrement cnt each cycle.
//   - When cnt==0: if the latched op is a load, data_out[owner] <= ram.data_out.
//   - Then go to DONE.
//   - Stores also take the full wait, so timing is uniform.
//  DONE (1 cycle):
//   - ack[owner]=1.
//   - rr_ptr = (owner+1) mod NREQ.
//   - No arbitration in this cycle, so a req still high during its ack is never re-granted.
//   - Go to IDLE.
//  Bus hold: ram.addr, ram.data_in and ram.data_type stay stable from ISSUE through DONE.
//   ram.op is non-NOP only in ISSUE.
//  Latency: req sampled at edge E. ISSUE in cycle E+1. ack high in cycle E+2+RD_LATENCY.
//   Peak throughput is one transaction per 3+RD_LATENCY cycles.
//  data_out[i] holds its value until requester i's next load completes.
//   A store leaves data_out[i] unchanged.
//  A req dropped after being granted does not abort the transaction. The ack still pulses.
//  A req raised while another transaction is in flight waits. Requester inputs are
//   sampled only at the IDLE grant.
//  At most one ack bit is high in any cycle. ack is never high in IDLE, ISSUE or WAIT.
//  rst_n asserted mid-transaction:
//   - Immediately force all outputs to reset values; no ack is emitted.
//   - The interrupted RAM op is abandoned.
// CONFIGURATION
//  RAM_ARB_FIXED_PRIO_EN
//   - Defined: fixed priority. The lowest index with req set wins, and rr_ptr is ignored
//     (held at 0), so requester 0 (loader) starves the others while it requests.
//   - Undefined (default): round-robin as described above.
// TESTING
//  1) Reset, then req[0]=1 with a store (addr=0x10, data_in=0xDEAD_BEEF_0000_0001, quad):
//     ram.op=store for exactly 1 cycle; ack[0] in cycle E+3; data_out[0] stays 0.
//  2) Then req[1] load from addr=0x10: ack[1] after 2+RD_LATENCY cycles,
//     data_out[1]=0xDEAD_BEEF_0000_0001, data_out[0] unchanged.
//  3) req[0] and req[1] held high continuously, 4 transactions:
//     grant order 0,1,0,1; ack never in the same cycle; no double grant while ack is high.
//  4) Same as 3 with RAM_ARB_FIXED_PRIO_EN defined:
//     grant order 0,0,0,0; req[1] is served only after req[0] drops.
//  5) rst_n pulsed low during WAIT:
//     ack stays 0, ram.op=OP_NOP, data_out cleared; after reset the next grant goes to
//     requester 0.
//  6) RD_LATENCY=3, load request, req dropped in the ISSUE cycle:
//     ack still pulses at E+5 and data_out holds the RAM word.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// One RAM port: the client drives op/data_type/addr/data_in, and the RAM returns data_out
// a fixed number of cycles after a load is issued.
interface if_ram #(
  parameter int ADDRW = 16,
  parameter int DW    = 64
);
  logic [1:0]       op;
  logic [1:0]       data_type;
  logic [ADDRW-1:0] addr;
  logic [DW-1:0]    data_in;
  logic [DW-1:0]    data_out;

  modport client (output op, data_type, addr, data_in, input data_out);
  modport server (input op, data_type, addr, data_in, output data_out);
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin share of one RAM port among NREQ requesters, one transaction in flight; req->ack is
// 2+RD_LATENCY cycles and req must be held until ack. RAM_ARB_FIXED_PRIO_EN selects fixed priority.
package pkg_ram;
  localparam int RAM_ADDRW     = 16;
  localparam int RAM_QUAD_SIZE = 64;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2} op_t;
  typedef enum logic [1:0] {DT_BYTE = 2'd0, DT_HALF = 2'd1, DT_WORD = 2'd2, DT_QUAD = 2'd3} data_type_t;
endpackage

module ram_arbiter #(
  parameter int NREQ       = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NREQ-1:0]                    req,
  output logic [NREQ-1:0]                    ack,
  input  pkg_ram::op_t                       op        [NREQ],
  input  pkg_ram::data_type_t                data_type [NREQ],
  input  logic [pkg_ram::RAM_ADDRW-1:0]      addr      [NREQ],
  input  logic [pkg_ram::RAM_QUAD_SIZE-1:0]  data_in   [NREQ],
  output logic [pkg_ram::RAM_QUAD_SIZE-1:0]  data_out  [NREQ],
  if_ram.client                              ram
);
  import pkg_ram::*;

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [IDXW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]          owner_q, owner_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  op_t                      op_q, op_d;
  data_type_t               dt_q, dt_d;
  logic [RAM_ADDRW-1:0]     addr_q, addr_d;
  logic [RAM_QUAD_SIZE-1:0] wdat_q, wdat_d;
  logic [RAM_QUAD_SIZE-1:0] data_out_q [NREQ];
  logic [RAM_QUAD_SIZE-1:0] data_out_d [NREQ];

  logic                     grant_vld;
  logic [IDXW-1:0]          grant_idx;

  // First requesting index at or after rr_ptr; rr_ptr stays 0 under fixed priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_vld && req[(int'(rr_ptr_q) + k) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = IDXW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dt_d       = dt_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d = grant_idx;
          op_d    = op[grant_idx];
          dt_d    = data_type[grant_idx];
          addr_d  = addr[grant_idx];
          wdat_d  = data_in[grant_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNTW'(RD_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // Stores wait the full latency too, keeping every transaction the same length.
        if (cnt_q == '0) begin
          if (op_q == OP_LOAD) data_out_d[owner_q] = ram.data_out;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DONE: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        rr_ptr_d = '0;
`else
        rr_ptr_d = IDXW'((int'(owner_q) + 1) % NREQ);
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      op_q     <= OP_NOP;
      dt_q     <= DT_BYTE;
      addr_q   <= '0;
      wdat_q   <= '0;
      for (int i = 0; i < NREQ; i++) data_out_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dt_q       <= dt_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      data_out_q <= data_out_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == DONE) ack[owner_q] = 1'b1;
  end

  assign ram.op        = (state_q == ISSUE) ? op_q : OP_NOP;
  assign ram.data_type = dt_q;
  assign ram.addr      = addr_q;
  assign ram.data_in   = wdat_q;
  assign data_out      = data_out_q;
endmodule
